mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 The block SHALL have parameter MEM_LAT, default 1, range 1..7, meaning MainMemory read latency in cycles.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  execute-stage request valid.
REQ-008 req_ready  out  1  block can accept a request.
REQ-009 req_write  in  1  1 = store, 0 = load.
REQ-010 req_addr  in  ADDR_W  byte address from the ALU result.
REQ-011 req_wdata  in  DATA_W  store data.
REQ-012 mem_we  out  1  drives MainMemory memWrite.
REQ-013 mem_addr  out  ADDR_W  drives MainMemory Addr.
REQ-014 mem_wdata  out  DATA_W  drives MainMemory write-data input.
REQ-015 mem_rdata  in  DATA_W  from MainMemory outputdata.
REQ-016 resp_valid  out  1  response to writeback valid.
REQ-017 resp_ready  in  1  writeback accepts the response.
REQ-018 resp_rdata  out  DATA_W  load data; 0 for stores and errors.
REQ-019 resp_err  out  1  misaligned access.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 The FSM SHALL have exactly these states: IDLE, WR, RD, RESP.
REQ-022 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid && req_ready, and addr, wdata and write are registered at that edge.
REQ-023 A misaligned request (req_addr[1:0] != 0) SHALL go IDLE->RESP with resp_err=1 and resp_rdata=0, and SHALL make no memory access.
REQ-024 An aligned store SHALL go IDLE->WR->RESP, with mem_we=1 for exactly the single WR cycle and mem_addr/mem_wdata holding the registered values.
REQ-025 An aligned load SHALL go IDLE->RD, stay in RD for exactly MEM_LAT+1 cycles with mem_addr held, and capture mem_rdata into resp_rdata on the last RD edge before entering RESP.
REQ-026 Latency from the accept edge to the first cycle of resp_valid SHALL be: store 2 cycles, load MEM_LAT+2 cycles, misaligned 1 cycle.
REQ-027 In RESP, resp_valid, resp_rdata and resp_err SHALL stay stable until resp_ready=1 is sampled; the FSM then goes to IDLE and resp_valid drops the next cycle.
REQ-028 There SHALL be no bypass: a new request is not accepted in the same cycle a response completes; throughput is at most one access per (latency+1) cycles.
REQ-029 mem_we SHALL be 0 in IDLE, RD and RESP.
REQ-030 mem_addr and mem_wdata SHALL hold their last values outside WR and RD.
REQ-031 req_* changes while busy SHALL be ignored.
REQ-032 The RD latency counter SHALL be 3 bits wide, load MEM_LAT on entry to RD, and decrement each cycle; the exit condition is count==0, with no wrap-around.

Reset
REQ-033 Assertion of rst_n=0 SHALL, asynchronously and at any state, force: state IDLE, mem_we 0, resp_valid 0, resp_err 0, resp_rdata 0, mem_addr 0, mem_wdata 0, counter 0, busy 0, req_ready 1.
REQ-034 A reset during WR SHALL drop mem_we immediately; no partial response is emitted after reset.
REQ-035 The first request SHALL be accepted on the first rising edge after rst_n deassertion.

Structure
REQ-036 Package mem_access_pkg SHALL hold the state enum (IDLE, WR, RD, RESP), ADDR_W/DATA_W defaults, ALIGN_MASK=2'b11 and the latency-counter width.
REQ-037 The block SHALL be a single module with no sub-module; its FSM, counter and registers are inline.

Verification
REQ-038 Store addr=0x8 data=0xDEADBEEF, resp_ready=1 -> mem_we high exactly 1 cycle with Addr=0x8; resp_valid 2 cycles after accept; rdata=0, err=0.
REQ-039 Load addr=0x8 after the above, MEM_LAT=1 -> resp_valid 3 cycles after accept; resp_rdata=0xDEADBEEF; mem_we never high.
REQ-040 Load addr=0x6 -> resp_valid 1 cycle after accept; err=1, rdata=0; mem_we stays 0 and mem_addr unchanged.
REQ-041 Load with resp_ready held 0 for 5 cycles -> resp_valid/rdata stable all 5 cycles; req_ready=0 until 1 cycle after the handshake.
REQ-042 rst_n pulsed low mid-WR of a store to 0x10 -> mem_we falls without waiting for a clock edge; no resp_valid; a later load of 0x10 with MEM_LAT=3 returns resp_valid after 5 cycles.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store memory access unit.
// Imported by mem_access_unit.
package mem_access_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W = 3;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RESP
  } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Load/store unit between execute and MainMemory.
// Single outstanding access, registered response held until accepted.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              w_accept;
  logic              w_misal;

  assign w_accept = req_valid && (r_state == IDLE);
  assign w_misal  = (req_addr[1:0] & ALIGN_MASK) != 2'b00;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_misal)        w_next = RESP;
          else if (req_write) w_next = WR;
          else                w_next = RD;
        end
      end
      WR:   w_next = RESP;
      RD:   if (r_cnt == '0) w_next = RESP;
      RESP: if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_err   <= w_misal;
        r_rdata <= '0;
        // misaligned requests never reach the memory port
        if (!w_misal) begin
          r_addr <= req_addr;
          if (req_write) r_wdata <= req_wdata;
          else           r_cnt   <= CNT_W'(MEM_LAT);
        end
      end
      if (r_state == RD) begin
        if (r_cnt == '0) r_rdata <= mem_rdata;
        else             r_cnt   <= r_cnt - 1'b1;
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign mem_we     = (r_state == WR);
  assign resp_valid = (r_state == RESP);
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a latency-modelled memory.
// Expected results come from a word-array model of memory semantics.
module tb_mem_access_unit;

  localparam int LAT = 1;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] phys_mem [0:63] = '{default: 32'h0};
  logic [31:0] ref_mem  [0:63] = '{default: 32'h0};
  logic [31:0] pipe     [0:LAT-1];

  mem_access_unit #(
    .ADDR_W(32),
    .DATA_W(32),
    .MEM_LAT(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MainMemory: synchronous write, read data appears LAT edges later
  always @(posedge clk) begin
    if (mem_we) phys_mem[mem_addr[7:2]] <= mem_wdata;
    pipe[0] <= phys_mem[mem_addr[7:2]];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          we_cnt;
    logic [31:0] we_addr;
    logic [31:0] we_data;
    int          bad;
    logic        drop;
    logic        acc;
  } obs_t;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          we_cnt;
  } exp_t;

  function automatic exp_t predict(logic w, logic [31:0] a,
                                   logic [31:0] d);
    exp_t e;
    e.err    = (a[1:0] != 2'b00);
    e.rdata  = 32'h0;
    e.we_cnt = 0;
    if (e.err) begin
      e.lat = 1;
    end else if (w) begin
      e.lat = 2;
      e.we_cnt = 1;
      ref_mem[a[7:2]] = d;
    end else begin
      e.lat = LAT + 2;
      e.rdata = ref_mem[a[7:2]];
    end
    return e;
  endfunction

  task automatic scramble();
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input int hold,
                       output obs_t o);
    int n;
    o = '{default: 0};
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    resp_ready = (hold == 0);
    o.acc = req_ready;
    @(posedge clk); #1;
    n = 1;
    while (!resp_valid && n < 40) begin
      if (mem_we) begin
        o.we_cnt++;
        o.we_addr = mem_addr;
        o.we_data = mem_wdata;
      end
      scramble();
      @(posedge clk); #1;
      n++;
    end
    o.lat   = resp_valid ? n : -1;
    o.rdata = resp_rdata;
    o.err   = resp_err;
    for (int i = 0; i < hold; i++) begin
      if (!resp_valid || resp_rdata !== o.rdata || resp_err !== o.err
          || req_ready || mem_we)
        o.bad++;
      scramble();
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    o.drop = !resp_valid && req_ready;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    resp_ready = 1'b1;
    #3;
    checks++;
    if ({req_ready, busy, mem_we, resp_valid, resp_err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 10000",
               {req_ready, busy, mem_we, resp_valid, resp_err});
    end
    checks++;
    if (resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 0", resp_rdata);
    end
    checks++;
    if (mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h want 0", mem_addr);
    end
    checks++;
    if (mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_wdata: got %h want 0", mem_wdata);
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_store();
    obs_t o;
    exp_t e;
    e = predict(1'b1, 32'h8, 32'hDEADBEEF);
    issue(1'b1, 32'h8, 32'hDEADBEEF, 0, o);
    checks++;
    if (o.acc !== 1'b1) begin
      errors++;
      $display("FAIL store_first_accept: got %b want 1", o.acc);
    end
    checks++;
    if (o.lat != e.lat) begin
      errors++;
      $display("FAIL store_lat: got %0d want %0d", o.lat, e.lat);
    end
    checks++;
    if (o.we_cnt != 1 || o.we_addr !== 32'h8) begin
      errors++;
      $display("FAIL store_we: got cnt=%0d addr=%h want cnt=1 addr=8",
               o.we_cnt, o.we_addr);
    end
    checks++;
    if (o.we_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_wdata: got %h want deadbeef", o.we_data);
    end
    checks++;
    if (o.rdata !== 32'h0 || o.err !== 1'b0) begin
      errors++;
      $display("FAIL store_resp: got rdata=%h err=%b want 0 0",
               o.rdata, o.err);
    end
    checks++;
    if (o.drop !== 1'b1) begin
      errors++;
      $display("FAIL store_drop: got %b want 1", o.drop);
    end
  endtask

  task automatic test_load();
    obs_t o;
    exp_t e;
    e = predict(1'b0, 32'h8, 32'h0);
    issue(1'b0, 32'h8, 32'h0, 0, o);
    checks++;
    if (o.lat != e.lat) begin
      errors++;
      $display("FAIL load_lat: got %0d want %0d", o.lat, e.lat);
    end
    checks++;
    if (o.rdata !== 32'hDEADBEEF || o.rdata !== e.rdata) begin
      errors++;
      $display("FAIL load_rdata: got %h want deadbeef", o.rdata);
    end
    checks++;
    if (o.we_cnt != 0 || o.err !== 1'b0) begin
      errors++;
      $display("FAIL load_we_err: got we=%0d err=%b want 0 0",
               o.we_cnt, o.err);
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    exp_t e;
    logic [31:0] prev;
    prev = mem_addr;
    e = predict(1'b0, 32'h6, 32'h0);
    issue(1'b0, 32'h6, 32'h0, 0, o);
    checks++;
    if (o.lat != e.lat) begin
      errors++;
      $display("FAIL misal_lat: got %0d want %0d", o.lat, e.lat);
    end
    checks++;
    if (o.err !== 1'b1 || o.rdata !== 32'h0) begin
      errors++;
      $display("FAIL misal_resp: got err=%b rdata=%h want 1 0",
               o.err, o.rdata);
    end
    checks++;
    if (o.we_cnt != 0) begin
      errors++;
      $display("FAIL misal_we: got %0d want 0", o.we_cnt);
    end
    checks++;
    if (mem_addr !== prev) begin
      errors++;
      $display("FAIL misal_addr: got %h want %h", mem_addr, prev);
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    exp_t e;
    e = predict(1'b0, 32'h8, 32'h0);
    issue(1'b0, 32'h8, 32'h0, 5, o);
    checks++;
    if (o.bad != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d bad cycles want 0", o.bad);
    end
    checks++;
    if (o.rdata !== e.rdata || o.lat != e.lat) begin
      errors++;
      $display("FAIL bp_resp: got %h/%0d want %h/%0d",
               o.rdata, o.lat, e.rdata, e.lat);
    end
    checks++;
    if (o.drop !== 1'b1) begin
      errors++;
      $display("FAIL bp_drop: got %b want 1", o.drop);
    end
  endtask

  task automatic test_reset_mid_write();
    obs_t o;
    exp_t e;
    int seen;
    e = predict(1'b1, 32'h10, 32'h12345678);
    issue(1'b1, 32'h10, 32'h12345678, 0, o);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_wr_enter: got we=%b want 1", mem_we);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, resp_valid, busy, req_ready} !== 4'b0001
        || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_async: got %b addr=%h want 0001 addr=0",
               {mem_we, resp_valid, busy, req_ready}, mem_addr);
    end
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_no_resp: got %0d valid cycles want 0", seen);
    end
    e = predict(1'b0, 32'h10, 32'h0);
    issue(1'b0, 32'h10, 32'h0, 0, o);
    checks++;
    if (o.lat != e.lat || o.rdata !== e.rdata) begin
      errors++;
      $display("FAIL rst_reload: got %0d/%h want %0d/%h",
               o.lat, o.rdata, e.lat, e.rdata);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i) << 4;
      e = predict(1'b1, a, 32'hA000_0000 + 32'(i));
      issue(1'b1, a, 32'hA000_0000 + 32'(i), 0, o);
      checks++;
      if (o.acc !== 1'b1 || o.lat != e.lat) begin
        errors++;
        $display("FAIL b2b_store: got acc=%b lat=%0d want 1 %0d",
                 o.acc, o.lat, e.lat);
      end
      e = predict(1'b0, a, 32'h0);
      issue(1'b0, a, 32'h0, 0, o);
      checks++;
      if (o.acc !== 1'b1 || o.rdata !== e.rdata) begin
        errors++;
        $display("FAIL b2b_load: got acc=%b rdata=%h want 1 %h",
                 o.acc, o.rdata, e.rdata);
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic w;
    logic [31:0] a;
    logic [31:0] d;
    int hold;
    for (int t = 0; t < 40; t++) begin
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      d = $urandom;
      hold = $urandom_range(0, 3);
      e = predict(w, a, d);
      issue(w, a, d, hold, o);
      checks++;
      if (o.lat != e.lat) begin
        errors++;
        $display("FAIL rnd_lat[%0d]: got %0d want %0d", t, o.lat, e.lat);
      end
      checks++;
      if (o.rdata !== e.rdata || o.err !== e.err) begin
        errors++;
        $display("FAIL rnd_resp[%0d]: got %h/%b want %h/%b",
                 t, o.rdata, o.err, e.rdata, e.err);
      end
      checks++;
      if (o.we_cnt != e.we_cnt) begin
        errors++;
        $display("FAIL rnd_we[%0d]: got %0d want %0d",
                 t, o.we_cnt, e.we_cnt);
      end
      if (e.we_cnt == 1) begin
        checks++;
        if (o.we_addr !== a || o.we_data !== d) begin
          errors++;
          $display("FAIL rnd_wport[%0d]: got %h/%h want %h/%h",
                   t, o.we_addr, o.we_data, a, d);
        end
      end
      checks++;
      if (o.bad != 0 || o.drop !== 1'b1 || o.acc !== 1'b1) begin
        errors++;
        $display("FAIL rnd_hs[%0d]: got bad=%0d drop=%b acc=%b want 0 1 1",
                 t, o.bad, o.drop, o.acc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_misaligned();
    test_backpressure();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
